// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Purpose  : Multi-cycle restoring divider, one quotient bit per clock, DIV/DIVU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             divz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic             nega_q, nega_d;
  logic             negq_q, negq_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Magnitudes stay unsigned so that |-2^31| = 2^31 is representable.
  assign w_mag_a = (Sign && A[WIDTH-1]) ? (-A) : A;
  assign w_mag_b = (Sign && B[WIDTH-1]) ? (-B) : B;

  // The dividend register doubles as the quotient shift register.
  assign w_shift = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    nega_d  = nega_q;
    negq_d  = negq_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = CW'(WIDTH - 1);
          prem_d  = '0;
          dvs_d   = w_mag_b;
          nega_d  = Sign & A[WIDTH-1];
          negq_d  = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
          divz_d  = 1'b0;
          if (B == '0) begin
            // Raw dividend is kept so the remainder can return A unmodified.
            zero_d  = 1'b1;
            dvd_d   = A;
            state_d = S_FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = w_mag_a;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        count_d = count_q - 1'b1;
        if (!w_trial[WIDTH]) begin
          prem_d = w_trial;
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = w_shift;
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (count_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (zero_q) begin
          quo_d  = '1;
          rem_d  = dvd_q;
          divz_d = 1'b1;
        end else begin
          quo_d  = negq_q ? (-dvd_q) : dvd_q;
          rem_d  = nega_q ? (-prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
          divz_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      nega_q  <= 1'b0;
      negq_q  <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      nega_q  <= nega_d;
      negq_q  <= negq_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign divz = divz_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module   : tb_divider
// Purpose  : Self-checking bench for divider: arithmetic reference plus directed ops.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Sign;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        divz;

  int n_pass  = 0;
  int n_total = 0;

  divider #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Sign (Sign),
    .busy (busy),
    .done (done),
    .quo  (quo),
    .rem  (rem),
    .divz (divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference result {divz, quo, rem} from plain integer arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q64, r64;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (s) begin
      sa  = $signed(a);
      sb  = $signed(b);
      q64 = sa / sb;
      r64 = sa % sb;
      return {1'b0, q64[31:0], r64[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {1'b0, uq, ur};
  endfunction

  // Transaction-level model: remaining cycles of the current op and the held results.
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_quo;
  logic [31:0] m_rem;
  logic        m_divz;
  logic [64:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_quo  <= 32'd0;
      m_rem  <= 32'd0;
      m_divz <= 1'b0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_divz <= m_pend[64];
          m_quo  <= m_pend[63:32];
          m_rem  <= m_pend[31:0];
        end
      end else if (start) begin
        m_pend <= ref_div(A, B, Sign);
        m_cnt  <= (B == 32'd0) ? 1 : 33;
        m_divz <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("quo",  quo, m_quo);
    check("rem",  rem, m_rem);
    check("divz", {31'd0, divz}, {31'd0, m_divz});
  end

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a; B = b; Sign = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input string name, input int n0, input int exp_lat,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int n = n0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"},  n, exp_lat);
    check({name, "_quo"},  quo, eq);
    check({name, "_rem"},  rem, er);
    check({name, "_divz"}, {31'd0, divz}, {31'd0, ez});
  endtask

  initial begin
    start = 1'b0; A = '0; B = '0; Sign = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_quo",  quo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 100/7, busy across the whole run
    issue(32'd100, 32'd7, 1'b0);
    wait_done("u100_7", 0, 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);

    // Signed and unsigned -7/2
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("s_m7_2", 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("u_m7_2", 0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);

    // Most-negative dividend
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("s_ovf", 0, 33, 32'h8000_0000, 32'd0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("u_ovf", 0, 33, 32'd0, 32'h8000_0000, 1'b0);

    // Divide by zero, signed flag ignored; then a valid op clears divz
    issue(32'd5, 32'd0, 1'b1);
    wait_done("dz", 0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    issue(32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_done("dz_neg", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
    issue(32'd20, 32'd6, 1'b0);
    check("dz_clear", {31'd0, divz}, 32'd0);
    wait_done("after_dz", 0, 33, 32'd3, 32'd2, 1'b0);

    // Start mid-operation is ignored; back-to-back start in the done cycle
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    issue(32'd9, 32'd3, 1'b1);
    A = 32'd1; B = 32'd1;
    wait_done("busy_ign", 10, 33, 32'd14, 32'd2, 1'b0);
    issue(32'd1000, 32'hFFFF_FFF6, 1'b1);
    wait_done("b2b", 0, 33, 32'hFFFF_FF9C, 32'd0, 1'b0);

    // Asynchronous reset mid-operation
    issue(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_quo",  quo, 32'd0);
    check("arst_rem",  rem, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd50, 32'd5, 1'b0);
    wait_done("post_rst", 0, 33, 32'd10, 32'd0, 1'b0);

    // Random regression against the reference model
    for (int mode = 0; mode < 2; mode++) begin
      for (int k = 0; k < 150; k++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        case ($urandom_range(0, 3))
          0: rb = 32'd0;
          1: rb = $urandom_range(1, 20);
          2: rb = -($urandom_range(1, 20));
          default: rb = $urandom;
        endcase
        issue(ra, rb, mode[0]);
        repeat ($urandom_range(33, 36)) begin
          if (!busy) break;
          @(negedge clk);
        end
      end
    end
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
